// File: rtl/i2s_serm_if.sv
// Sample handshake and I2S serial lines of the i2s_serm transmitter.
// master = sample producer, slave = i2s_serm.
interface i2s_serm_if;
  logic [23:0] lft_chnnl;
  logic [23:0] rght_chnnl;
  logic        wrt_smpl;
  logic        rdy;
  logic        underflow;
  logic        I2S_sclk;
  logic        I2S_ws;
  logic        I2S_data;

  modport master (
    output lft_chnnl, rght_chnnl, wrt_smpl,
    input  rdy, underflow, I2S_sclk, I2S_ws, I2S_data
  );

  modport slave (
    input  lft_chnnl, rght_chnnl, wrt_smpl,
    output rdy, underflow, I2S_sclk, I2S_ws, I2S_data
  );
endinterface

// File: rtl/i2s_serm.sv
// Transmit-side I2S serializer: single-entry sample buffer, sclk/ws generation, MSB-first Philips framing.
// Define I2S_SERM_HOLD_EN to retransmit the previous samples on underflow instead of zeros.
module i2s_serm #(
  parameter int SCLK_DIV = 32
) (
  input logic       clk,
  input logic       rst_n,
  i2s_serm_if.slave bus
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(HALF - 1);
  localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);

  logic [DIVW-1:0] r_div;
  logic            r_sclk;
  logic [5:0]      r_bit_cnt;
  logic            r_ws;
  logic            r_data;
  logic [23:0]     r_left_sh;
  logic [23:0]     r_right_sh;
  logic [23:0]     r_hold_l;
  logic [23:0]     r_hold_r;
  logic            r_rdy;
  logic            r_underflow;
`ifdef I2S_SERM_HOLD_EN
  logic [23:0]     r_last_l;
  logic [23:0]     r_last_r;
`endif

  logic            w_tc;
  logic            w_fall;
  logic [5:0]      w_next_cnt;
  logic            w_load;
  logic            w_accept;
  logic [23:0]     w_fill_l;
  logic [23:0]     w_fill_r;

  assign w_tc       = (r_div == DIV_LAST);
  assign w_fall     = w_tc & r_sclk;
  assign w_next_cnt = r_bit_cnt + 6'd1;
  assign w_load     = w_fall & (w_next_cnt == 6'd63);
  // rdy=1 means the holding buffer is empty, so only an empty buffer accepts a write
  assign w_accept   = bus.wrt_smpl & r_rdy;

  // Frame source: buffered samples when full, otherwise the underflow fill.
  always_comb begin
    w_fill_l = 24'h000000;
    w_fill_r = 24'h000000;
    if (!r_rdy) begin
      w_fill_l = r_hold_l;
      w_fill_r = r_hold_r;
    end else begin
`ifdef I2S_SERM_HOLD_EN
      w_fill_l = r_last_l;
      w_fill_r = r_last_r;
`else
      w_fill_l = 24'h000000;
      w_fill_r = 24'h000000;
`endif
    end
  end

  // Bit-clock divider: sclk toggles at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + DIV_ONE;
    end
  end

  // Slot counter, word select and serial data, all advancing on sclk falling events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= 6'd62;
      r_ws       <= 1'b1;
      r_data     <= 1'b0;
      r_left_sh  <= 24'h000000;
      r_right_sh <= 24'h000000;
    end else if (w_fall) begin
      r_bit_cnt <= w_next_cnt;
      // ws leads the MSB by one slot, so it flips entering slots 31 and 63
      r_ws      <= (w_next_cnt >= 6'd31) && (w_next_cnt != 6'd63);
      if (w_load) begin
        r_left_sh  <= w_fill_l;
        r_right_sh <= w_fill_r;
        r_data     <= 1'b0;
      end else if (w_next_cnt <= 6'd23) begin
        r_data    <= r_left_sh[23];
        r_left_sh <= {r_left_sh[22:0], 1'b0};
      end else if ((w_next_cnt >= 6'd32) && (w_next_cnt <= 6'd55)) begin
        r_data     <= r_right_sh[23];
        r_right_sh <= {r_right_sh[22:0], 1'b0};
      end else begin
        r_data <= 1'b0;
      end
    end
  end

  // Holding buffer, rdy and underflow; a load from a full buffer and a write never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_l    <= 24'h000000;
      r_hold_r    <= 24'h000000;
      r_rdy       <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_load & r_rdy;
      if (w_load && !r_rdy) begin
        r_rdy <= 1'b1;
      end else if (w_accept) begin
        r_rdy <= 1'b0;
      end
      if (w_accept) begin
        r_hold_l <= bus.lft_chnnl;
        r_hold_r <= bus.rght_chnnl;
      end
    end
  end

`ifdef I2S_SERM_HOLD_EN
  // Remember the last real samples so an underflow frame can repeat them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= 24'h000000;
      r_last_r <= 24'h000000;
    end else if (w_load && !r_rdy) begin
      r_last_l <= r_hold_l;
      r_last_r <= r_hold_r;
    end
  end
`endif

  assign bus.rdy       = r_rdy;
  assign bus.underflow = r_underflow;
  assign bus.I2S_sclk  = r_sclk;
  assign bus.I2S_ws    = r_ws;
  assign bus.I2S_data  = r_data;

endmodule

// File: tb/tb_i2s_serm.sv
// Directed bench for i2s_serm: a bench-side I2S receiver decodes each frame from the serial lines.
module tb_i2s_serm;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  i2s_serm_if bus ();

  i2s_serm #(.SCLK_DIV(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [23:0] l, input logic [23:0] r);
    bus.lft_chnnl  = l;
    bus.rght_chnnl = r;
    bus.wrt_smpl   = 1'b1;
    @(negedge clk);
    bus.wrt_smpl   = 1'b0;
  endtask

  // Decode one frame starting at a ws falling edge; returns after the slot-62 rising edge.
  task automatic recv_frame(input bit at_fall, output logic [23:0] l, output logic [23:0] r,
                            output logic uf_load, output int uf_other, output int slot_err);
    logic prev_ws;
    logic prev_sclk;
    logic exp_ws;
    bit   found;
    bit   got;
    int   slot;
    l = 24'h000000; r = 24'h000000; uf_load = 1'b0; uf_other = 0; slot_err = 0;
    found = at_fall;
    if (at_fall) uf_load = bus.underflow;
    prev_ws = bus.I2S_ws;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (prev_ws && !bus.I2S_ws) begin
        found   = 1'b1;
        uf_load = bus.underflow;
      end else if (bus.underflow) begin
        uf_other++;
      end
      prev_ws = bus.I2S_ws;
    end
    check("ws_fall_seen", {47'd0, found}, 48'd1);
    if (!found) return;
    prev_sclk = bus.I2S_sclk;
    slot = 63;
    for (int k = 0; k < 64; k++) begin
      got = 1'b0;
      for (int t = 0; t < 64 && !got; t++) begin
        @(negedge clk);
        if (bus.underflow) uf_other++;
        if (bus.I2S_sclk && !prev_sclk) got = 1'b1;
        prev_sclk = bus.I2S_sclk;
      end
      if (!got) slot_err++;
      exp_ws = (slot >= 31) && (slot <= 62);
      if (bus.I2S_ws !== exp_ws) slot_err++;
      if (slot <= 23) l = {l[22:0], bus.I2S_data};
      else if (slot >= 32 && slot <= 55) r = {r[22:0], bus.I2S_data};
      else if (bus.I2S_data !== 1'b0) slot_err++;
      slot = (slot == 63) ? 0 : slot + 1;
    end
  endtask

  // Reset, release, write one sample pair early and check divider/ws timing plus the first frame.
  task automatic reset_and_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
    logic [23:0] gl, gr;
    logic        ufl;
    int          ufo, serr;
    rst_n = 1'b0;
    #1;
    check({tag, "_reset_outs"},
          {43'd0, bus.I2S_sclk, bus.I2S_ws, bus.I2S_data, bus.rdy, bus.underflow}, 48'b01010);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.lft_chnnl = l; bus.rght_chnnl = r; bus.wrt_smpl = 1'b1;
      end
      if (i == 3) begin
        bus.wrt_smpl = 1'b0;
        check({tag, "_rdy_after_write"}, {47'd0, bus.rdy}, 48'd0);
      end
      if (i == 15) check({tag, "_sclk_low_c15"}, {47'd0, bus.I2S_sclk}, 48'd0);
      if (i == 16) check({tag, "_sclk_rise_c16"}, {47'd0, bus.I2S_sclk}, 48'd1);
      if (i == 31) check({tag, "_ws_high_c31"}, {47'd0, bus.I2S_ws}, 48'd1);
      if (i == 32) begin
        check({tag, "_ws_fall_c32"}, {47'd0, bus.I2S_ws}, 48'd0);
        check({tag, "_rdy_on_load"}, {47'd0, bus.rdy}, 48'd1);
      end
    end
    recv_frame(1'b1, gl, gr, ufl, ufo, serr);
    check({tag, "_frame"}, {gl, gr}, {l, r});
    check({tag, "_uf_load"}, {47'd0, ufl}, 48'd0);
    check({tag, "_uf_other"}, 48'(ufo), 48'd0);
    check({tag, "_slot_err"}, 48'(serr), 48'd0);
  endtask

  logic [23:0] gl, gr;
  logic        ufl;
  int          ufo, serr;
  bit          seen;

  initial begin
    bus.lft_chnnl  = 24'h000000;
    bus.rght_chnnl = 24'h000000;
    bus.wrt_smpl   = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values, timing and a single frame
    reset_and_frame("rst1", 24'hA5F00F, 24'h123456);
    check("rdy_idle_after_f1", {47'd0, bus.rdy}, 48'd1);

    // Write while full: the second write must be ignored
    write(24'h111111, 24'h111111);
    check("full_rdy_after_w1", {47'd0, bus.rdy}, 48'd0);
    write(24'h222222, 24'h222222);
    check("full_rdy_after_w2", {47'd0, bus.rdy}, 48'd0);
    recv_frame(1'b0, gl, gr, ufl, ufo, serr);
    check("full_frame", {gl, gr}, {24'h111111, 24'h111111});
    check("full_uf", {46'd0, ufl, 1'b0} | 48'(ufo), 48'd0);
    check("full_rdy_after_load", {47'd0, bus.rdy}, 48'd1);

    // Extreme values, then withhold writes to force an underflow
    write(24'h7FFFFF, 24'h800000);
    recv_frame(1'b0, gl, gr, ufl, ufo, serr);
    check("ext_frame", {gl, gr}, {24'h7FFFFF, 24'h800000});
    check("ext_slot_err", 48'(serr), 48'd0);
    recv_frame(1'b0, gl, gr, ufl, ufo, serr);
`ifdef I2S_SERM_HOLD_EN
    check("uf_frame", {gl, gr}, {24'h7FFFFF, 24'h800000});
`else
    check("uf_frame", {gl, gr}, {24'h000000, 24'h000000});
`endif
    check("uf_pulse_at_load", {47'd0, ufl}, 48'd1);
    check("uf_pulse_once", 48'(ufo), 48'd0);
    check("uf_rdy", {47'd0, bus.rdy}, 48'd1);

    // Same-clk collision: the load edge is 16 clks after the slot-62 rise
    repeat (15) @(negedge clk);
    bus.lft_chnnl = 24'h0ABCDE; bus.rght_chnnl = 24'h654321; bus.wrt_smpl = 1'b1;
    @(negedge clk);
    bus.wrt_smpl = 1'b0;
    check("coll_underflow", {47'd0, bus.underflow}, 48'd1);
    check("coll_rdy", {47'd0, bus.rdy}, 48'd0);
    recv_frame(1'b0, gl, gr, ufl, ufo, serr);
    check("coll_frame", {gl, gr}, {24'h0ABCDE, 24'h654321});
    check("coll_next_uf", {47'd0, ufl}, 48'd0);

    // Mid-frame reset while I2S_data is high
    write(24'hFFFFFF, 24'h000001);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (bus.I2S_data === 1'b1) seen = 1'b1;
    end
    check("data_high_before_rst", {47'd0, seen}, 48'd1);
    reset_and_frame("rst2", 24'h5A5A5A, 24'hC3C3C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
